// File: rtl/fpu_arbiter.sv
// Round-robin sequencer sharing one multi-cycle fpu among NREQ requesters.
// Optional watchdog on the fpu wait phase is enabled with macro FPU_TIMEOUT_EN.
module fpu_arbiter #(
  parameter int NREQ     = 4,
  parameter int WAIT_MAX = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [2*NREQ-1:0]    req_funct,
  input  logic [32*NREQ-1:0]   req_a,
  input  logic [32*NREQ-1:0]   req_b,
  output logic [NREQ-1:0]      resp_valid,
  input  logic [NREQ-1:0]      resp_ready,
  output logic [31:0]          resp_data,
  output logic                 resp_err,
  output logic [1:0]           fpu_funct,
  output logic [31:0]          fpu_a,
  output logic [31:0]          fpu_b,
  output logic                 fpu_start,
  input  logic [31:0]          fpu_o,
  input  logic                 fpu_finish,
  output logic                 busy
);

  localparam int IW = $clog2(NREQ);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          state;
  state_t          state_next;
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   grant;
  logic [IW-1:0]   pick;
  logic            pick_found;
  logic            finish_q;
  logic            finish_edge;
  logic            wait_expired;
  logic            accept;
  logic            handshake;

  assign finish_edge = fpu_finish & ~finish_q;
  assign busy        = (state != IDLE);

  // First pending requester at or after rr_ptr, wrapping around.
  always_comb begin
    int idx;
    idx        = 0;
    pick       = '0;
    pick_found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      idx = (int'(rr_ptr) + i) % NREQ;
      if (!pick_found && req_valid[idx]) begin
        pick       = IW'(idx);
        pick_found = 1'b1;
      end
    end
  end

`ifdef FPU_TIMEOUT_EN
  localparam int CW = $clog2(WAIT_MAX);
  logic [CW-1:0] wait_cnt;

  always_ff @(posedge clk) begin
    if (rst || state == ISSUE) begin
      wait_cnt <= '0;
    end else if (state == WAIT) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign wait_expired = (state == WAIT) && (wait_cnt == CW'(WAIT_MAX - 1));
`else
  // No watchdog: the wait never expires (WAIT_MAX only sizes the watchdog).
  assign wait_expired = (WAIT_MAX < 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    req_ready  = '0;
    resp_valid = '0;
    fpu_start  = 1'b0;
    accept     = 1'b0;
    handshake  = 1'b0;
    case (state)
      IDLE: begin
        if (pick_found && !rst) begin
          accept          = 1'b1;
          req_ready[pick] = 1'b1;
          state_next      = ISSUE;
        end
      end
      ISSUE: begin
        fpu_start  = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        if (finish_edge || wait_expired) begin
          state_next = RESP;
        end
      end
      RESP: begin
        resp_valid[grant] = 1'b1;
        if (resp_ready[grant]) begin
          handshake  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand latch, result capture and round-robin pointer update.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr    <= '0;
      grant     <= '0;
      finish_q  <= 1'b0;
      fpu_funct <= '0;
      fpu_a     <= '0;
      fpu_b     <= '0;
      resp_data <= '0;
      resp_err  <= 1'b0;
    end else begin
      finish_q <= fpu_finish;
      if (accept) begin
        grant     <= pick;
        fpu_funct <= req_funct[2*int'(pick) +: 2];
        fpu_a     <= req_a[32*int'(pick) +: 32];
        fpu_b     <= req_b[32*int'(pick) +: 32];
      end
      if (state == WAIT && finish_edge) begin
        resp_data <= fpu_o;
        resp_err  <= 1'b0;
      end else if (state == WAIT && wait_expired) begin
        resp_data <= 32'h7FC00000;
        resp_err  <= 1'b1;
      end
      if (handshake) begin
        rr_ptr <= (grant == IW'(NREQ - 1)) ? '0 : grant + 1'b1;
      end
    end
  end

endmodule

// File: doc/fpu_arbiter.md
Name: fpu_arbiter

Overview:
- Round-robin arbiter/sequencer that shares one multi-cycle fpu (ports clk, funct[1:0], a, b, o, finish) between NREQ requesters.
- Grants one requester at a time and latches its operands. Drives them stable into the fpu, waits for finish, then returns the result to the granted requester with a valid/ready handshake.
- Sits between the requester ports and the single fpu instance.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WAIT_MAX, 1024, watchdog limit in cycles; used only with FPU_TIMEOUT_EN.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-requester request pending.
- req_ready  out  NREQ  one-hot; high for the single cycle a request is accepted.
- req_funct  in  2*NREQ  packed fpu opcode, requester i at [2i+1:2i].
- req_a  in  32*NREQ  packed operand a, requester i at [32i+31:32i].
- req_b  in  32*NREQ  packed operand b.
- resp_valid  out  NREQ  one-hot; result available for requester i.
- resp_ready  in  NREQ  requester i accepts result.
- resp_data  out  32  result, shared bus, valid only with resp_valid.
- resp_err  out  1  result is a timeout abort (always 0 without FPU_TIMEOUT_EN).
- fpu_funct  out  2  to fpu funct.
- fpu_a  out  32  to fpu a.
- fpu_b  out  32  to fpu b.
- fpu_start  out  1  one-cycle pulse marking a new operation.
- fpu_o  in  32  from fpu o.
- fpu_finish  in  1  from fpu finish (level; rising edge = done).
- busy  out  1  high in any state except IDLE.

Behaviour:
- FSM states: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- Reset: state=IDLE, rr_ptr=0, finish_q=0, all outputs 0 (req_ready, resp_valid, resp_data, resp_err, fpu_funct/a/b, fpu_start, busy).
- IDLE, no request: stay in IDLE.
- IDLE, any req_valid:
  - Pick the first set bit scanning rr_ptr, rr_ptr+1, … mod NREQ.
  - Assert req_ready[g] combinationally that cycle.
  - Latch funct/a/b of g into fpu_funct/fpu_a/fpu_b; store g.
  - Go to ISSUE.
- ISSUE: fpu_start=1 for exactly this cycle; go to WAIT.
- WAIT:
  - fpu_funct/a/b held constant.
  - finish_q registers fpu_finish every cycle.
  - When fpu_finish & ~finish_q (rising edge), latch fpu_o into resp_data, resp_err=0, go to RESP.
  - A finish already high on entry to WAIT is ignored until it drops and rises again.
- RESP:
  - resp_valid[g]=1, held with resp_data stable until resp_ready[g]=1.
  - On that handshake cycle: rr_ptr=(g+1) mod NREQ, resp_valid cleared next cycle, go to IDLE.
  - resp_ready of other requesters is ignored.
- Throughput: at most one operation in flight.
- Minimum turnaround: accept(0), start(1), first WAIT cycle(2), finish edge seen N cycles later, RESP until accepted, IDLE one cycle before the next grant.
- Fairness: each requester with req_valid held continuously is granted within NREQ operations.
- Requests arriving or dropping in non-IDLE states have no effect. A requester must hold req_valid and operands until req_ready.
- Same requester re-requesting while its response is pending: not accepted until RESP completes.
- rst asserted in any state (including mid-WAIT): return to IDLE with reset values on the next edge. Any fpu result in progress is discarded; resp_valid is not raised for it.
- busy = (state != IDLE).

Optional Feature:
- Macro: FPU_TIMEOUT_EN.
- With macro:
  - A cycle counter clears on entering WAIT and increments each WAIT cycle.
  - If it reaches WAIT_MAX-1 without a finish edge: go to RESP with resp_data=32'h7FC00000 (quiet NaN), resp_err=1.
  - A finish edge in the same cycle as the limit wins (normal result, resp_err=0).
- Without macro: no counter; WAIT waits indefinitely; resp_err tied 0.

Test Plan:
- Single request:
  - Stimulus: rst, then requester 0 valid, funct=2'b00, a=32'h3F800000, b=32'h40000000; fpu model raises finish 5 cycles after start with o=32'h40400000.
  - Response: req_ready[0] pulses once, fpu_start one cycle later, resp_valid[0] with resp_data=32'h40400000, busy low after resp_ready.
- Round robin:
  - Stimulus: all 4 requesters valid continuously.
  - Response: grant order 0,1,2,3,0; no requester granted twice before the others.
- Backpressure:
  - Stimulus: resp_ready[1] held low for 10 cycles after resp_valid[1].
  - Response: resp_valid and resp_data stable all 10 cycles, no new req_ready, grant proceeds after the handshake.
- Stale finish:
  - Stimulus: fpu_finish still high from the previous op when WAIT is entered, then low 2 cycles, then high.
  - Response: only the second rising edge captures fpu_o.
- Reset mid-operation:
  - Stimulus: rst asserted 2 cycles into WAIT.
  - Response: next cycle all outputs 0, state IDLE, rr_ptr 0, no resp_valid for the aborted op.
- Timeout (FPU_TIMEOUT_EN, WAIT_MAX=16):
  - Stimulus: finish never rises.
  - Response: resp_valid after 16 WAIT cycles with resp_data=32'h7FC00000, resp_err=1.
